subtractor_16bit_seq: RTL and testbench
=======================================

SUBTRACTOR_16BIT_SEQ -- requirements
Module: subtractor_16bit_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports listed clock first, then reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only while ready=1.
REQ-005 num_1  input  16  minuend, unsigned or two's complement.
REQ-006 num_2  input  16  subtrahend.
REQ-007 b  input  1  borrow-in.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 diff  output  16  registered result.
REQ-010 borrow  output  1  registered borrow-out (unsigned underflow).
REQ-011 zero  output  1  registered; diff==0x0000.
REQ-012 overflow  output  1  registered; signed overflow of the subtraction.
REQ-013 done  output  1  one-cycle pulse when diff/borrow/zero/overflow are updated.

Function
REQ-014 The block SHALL implement states IDLE, LOW, HIGH and DONE.
REQ-015 In IDLE, ready SHALL be 1; in all other states ready SHALL be 0.
REQ-016 IDLE->LOW on a rising edge with start=1; num_1, num_2 and b are captured on that edge.
REQ-017 start while ready=0 SHALL be ignored, without affecting the operation in flight or any output.
REQ-018 LOW: 8-bit subtract, low byte = num_1[7:0] - num_2[7:0] - b; the low result and the internal borrow are stored; next state HIGH.
REQ-019 HIGH: high byte = num_1[15:8] - num_2[15:8] - internal borrow; next state DONE.
REQ-020 DONE: on the same edge, diff, borrow, zero and overflow are registered, and done=1 for exactly this one cycle; next state IDLE.
REQ-021 Latency: with start sampled at edge N, done is high in the cycle after edge N+2; back-to-back throughput is one operation per 4 cycles.
REQ-022 The block SHALL compute diff = (num_1 - num_2 - b) mod 2^16.
REQ-023 borrow SHALL be 1 iff num_1 < num_2 + b, computed unsigned with 17-bit precision.
REQ-024 overflow SHALL be 1 iff num_1[15] != num_2[15] and diff[15] != num_1[15]; b participates in diff.
REQ-025 zero SHALL be 1 iff all 16 diff bits are 0, independent of borrow.
REQ-026 diff, borrow, zero and overflow SHALL hold their values until the next DONE state; they do not change during LOW or HIGH.
REQ-027 Input changes after the capture edge SHALL NOT affect the result.
REQ-028 In IDLE, start=1 and the DONE->IDLE return SHALL NOT overlap; start is first accepted in the IDLE cycle that follows DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and set ready=1, done=0, diff=0x0000, borrow=0, zero=0, overflow=0, and clear the captured operands and internal borrow.
REQ-030 Reset during LOW, HIGH or DONE SHALL abort the operation, with no done pulse and no partial result visible.
REQ-031 The first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Verification
REQ-032 num_1=0x1234, num_2=0x0034, b=0 -> diff=0x1200, borrow=0, zero=0, overflow=0, done 3 cycles after start.
REQ-033 0x0100 - 0x0001, b=0 -> diff=0x00FF, borrow=0; checks the cross-byte internal borrow. Also 0x0000 - 0x0001 -> diff=0xFFFF, borrow=1.
REQ-034 0x8000 - 0x0001 -> diff=0x7FFF, overflow=1, borrow=0. Also 0x0005 - 0x0004 with b=1 -> diff=0x0000, zero=1, borrow=0.
REQ-035 Assert start again in LOW and in HIGH with different operands -> ignored; the first result is unchanged, a single done pulse occurs, and ready=0 until IDLE.
REQ-036 Drop rst_n in HIGH -> ready=1 and all outputs 0 asynchronously, no done; a new start afterwards completes correctly.
REQ-037 Issue two back-to-back operations, with start held high continuously -> the second is accepted on the IDLE edge after DONE, giving done pulses 4 cycles apart.

Source files
------------

// File: rtl/subtractor_16bit_seq.sv
// Multi-cycle 16-bit subtractor: low byte then high byte through an 8-bit
// datapath, with registered flags published in a single DONE cycle.
module subtractor_16bit_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_1,
  input  logic [15:0] num_2,
  input  logic        b,
  output logic        ready,
  output logic [15:0] diff,
  output logic        borrow,
  output logic        zero,
  output logic        overflow,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [15:0] r_num_1;
  logic [15:0] r_num_2;
  logic        r_b;
  logic [7:0]  r_lo;
  logic        r_ib;
  logic [15:0] r_diff;
  logic        r_borrow;
  logic        r_zero;
  logic        r_ovf;
  logic        r_done;

  logic [8:0]  w_lo_sub;
  logic [8:0]  w_hi_sub;
  logic [15:0] w_diff;

  // Bit 8 of each 9-bit difference is the byte borrow-out (result went negative).
  assign w_lo_sub = {1'b0, r_num_1[7:0]}  - {1'b0, r_num_2[7:0]}  - {8'd0, r_b};
  assign w_hi_sub = {1'b0, r_num_1[15:8]} - {1'b0, r_num_2[15:8]} - {8'd0, r_ib};
  assign w_diff   = {w_hi_sub[7:0], r_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_num_1  <= '0;
      r_num_2  <= '0;
      r_b      <= 1'b0;
      r_lo     <= '0;
      r_ib     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_1 <= num_1;
            r_num_2 <= num_2;
            r_b     <= b;
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          r_lo    <= w_lo_sub[7:0];
          r_ib    <= w_lo_sub[8];
          r_state <= S_HIGH;
        end
        S_HIGH: begin
          // Outputs and done are registered together so they appear in DONE.
          r_diff   <= w_diff;
          r_borrow <= w_hi_sub[8];
          r_zero   <= (w_diff == '0);
          r_ovf    <= (r_num_1[15] != r_num_2[15]) && (w_diff[15] != r_num_1[15]);
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign done     = r_done;

endmodule

// File: tb/tb_subtractor_16bit_seq.sv
// Scoreboard bench for subtractor_16bit_seq: expected results are queued at
// stimulus time and popped when done pulses.
module tb_subtractor_16bit_seq;

  typedef struct packed {
    logic [15:0] d;
    logic        br;
    logic        z;
    logic        ov;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] num_1;
  logic [15:0] num_2;
  logic        b;
  logic        ready;
  logic [15:0] diff;
  logic        borrow;
  logic        zero;
  logic        overflow;
  logic        done;

  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];

  subtractor_16bit_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_1    (num_1),
    .num_2    (num_2),
    .b        (b),
    .ready    (ready),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .overflow (overflow),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] s, input logic bin);
    logic [16:0] full;
    res_t r;
    full = {1'b0, a} - {1'b0, s} - {16'd0, bin};
    r.d  = full[15:0];
    r.br = full[16];
    r.z  = (full[15:0] == 16'h0000);
    r.ov = (a[15] != s[15]) && (full[15] != a[15]);
    return r;
  endfunction

  // Called just after a falling edge: presents an operation for one rising
  // edge, then scrambles the inputs so late changes would corrupt a bad capture.
  task automatic drive_op(input logic [15:0] a, input logic [15:0] s, input logic bin, input bit push);
    num_1 = a;
    num_2 = s;
    b     = bin;
    start = 1'b1;
    if (push) sb.push_back(model(a, s, bin));
    @(negedge clk);
    start = 1'b0;
    num_1 = ~a;
    num_2 = a ^ s;
    b     = ~bin;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    num_1 = 16'hFFFF;
    num_2 = 16'h0001;
    b     = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (ready !== 1'b1)     begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (diff !== 16'h0000)  begin failures++; $display("FAIL reset_diff got=%h exp=0000", diff); end
      checks++; if (borrow !== 1'b0)    begin failures++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
      checks++; if (zero !== 1'b0)      begin failures++; $display("FAIL reset_zero got=%b exp=0", zero); end
      checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      start = 1'b1;
      repeat (2) @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [15:0] ta[7] = '{16'h1234, 16'h0100, 16'h0000, 16'h8000, 16'h0005, 16'h7FFF, 16'h0000};
    logic [15:0] ts[7] = '{16'h0034, 16'h0001, 16'h0001, 16'h0001, 16'h0004, 16'hFFFF, 16'hFFFF};
    logic        tb_[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] a, s;
    logic        bin;
    res_t        e;
    int          n;
    for (int i = 0; i < 11; i++) begin
      if (i < 7) begin
        a = ta[i]; s = ts[i]; bin = tb_[i];
      end else begin
        a = 16'($urandom); s = 16'($urandom); bin = 1'($urandom);
      end
      drive_op(a, s, bin, 1'b1);
      wait_done(8, n);
      checks++;
      if (n + 1 !== 3) begin
        failures++; $display("FAIL vec%0d_latency got=%0d exp=3", i, n + 1);
      end
      if (n > 0 && sb.size() > 0) begin
        e = sb.pop_front();
        checks++; if (diff !== e.d)      begin failures++; $display("FAIL vec%0d_diff got=%h exp=%h", i, diff, e.d); end
        checks++; if (borrow !== e.br)   begin failures++; $display("FAIL vec%0d_borrow got=%b exp=%b", i, borrow, e.br); end
        checks++; if (zero !== e.z)      begin failures++; $display("FAIL vec%0d_zero got=%b exp=%b", i, zero, e.z); end
        checks++; if (overflow !== e.ov) begin failures++; $display("FAIL vec%0d_overflow got=%b exp=%b", i, overflow, e.ov); end
      end
      @(negedge clk);
      checks++;
      if ({done, ready} !== 2'b01) begin
        failures++; $display("FAIL vec%0d_after_done got={done,ready}=%b exp=01", i, {done, ready});
      end
    end
  endtask

  task automatic test_ignore_start;
    res_t e;
    int   extra;
    drive_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    start = 1'b1; num_1 = 16'h1111; num_2 = 16'h2222; b = 1'b1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ign_ready_low got=%b exp=0", ready); end
    @(negedge clk);
    num_1 = 16'hAAAA; num_2 = 16'h0F0F;
    checks++;
    if ({ready, done} !== 2'b00) begin
      failures++; $display("FAIL ign_high got={ready,done}=%b exp=00", {ready, done});
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({diff, borrow, zero, overflow} !== e) begin
        failures++; $display("FAIL ign_result got=%h exp=%h", {diff, borrow, zero, overflow}, e);
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra !== 0)    begin failures++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ign_ready_idle got=%b exp=1", ready); end
  endtask

  task automatic test_reset_mid;
    res_t e;
    int   n, extra;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", ready); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, done, diff, borrow, zero, overflow} !== {2'b10, 16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL rstmid_async got=%b_%b_%h_%b%b%b exp=1_0_0000_000", ready, done, diff, borrow, zero, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", extra); end
    drive_op(16'h4321, 16'h1234, 1'b1, 1'b1);
    wait_done(8, n);
    checks++; if (n + 1 !== 3) begin failures++; $display("FAIL rstmid_latency got=%0d exp=3", n + 1); end
    if (n > 0 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({diff, borrow, zero, overflow} !== e) begin
        failures++; $display("FAIL rstmid_result got=%h exp=%h", {diff, borrow, zero, overflow}, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    res_t e;
    int   n1, n2, extra;
    num_1 = 16'h0300; num_2 = 16'h0201; b = 1'b0; start = 1'b1;
    sb.push_back(model(16'h0300, 16'h0201, 1'b0));
    @(negedge clk);
    num_1 = 16'h8001; num_2 = 16'h7FFF; b = 1'b1;
    sb.push_back(model(16'h8001, 16'h7FFF, 1'b1));
    wait_done(8, n1);
    checks++; if (n1 !== 2) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=2", n1); end
    if (n1 > 0 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({diff, borrow, zero, overflow} !== e) begin
        failures++; $display("FAIL b2b_first_result got=%h exp=%h", {diff, borrow, zero, overflow}, e);
      end
    end
    wait_done(10, n2);
    start = 1'b0;
    checks++; if (n2 !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", n2); end
    if (n2 > 0 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({diff, borrow, zero, overflow} !== e) begin
        failures++; $display("FAIL b2b_second_result got=%h exp=%h", {diff, borrow, zero, overflow}, e);
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_extra_done got=%0d exp=0", extra); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
